// File: rtl/box_overlay_pkg.sv
// Shared types for the box overlay: FSM encoding, coordinate width, box record
// and the candidate validity rule.
package box_overlay_pkg;
  localparam int COORD_W = 12;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [23:0] DEF_BOX_COLOR = 24'hFF0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_TRACK  = 3'b010,
    ST_LOCKED = 3'b100
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t l;
    coord_t r;
    coord_t t;
    coord_t b;
  } box_t;

  // A box is usable only if it has positive extent and lies inside the frame.
  function automatic logic box_ok(input box_t bx, input int unsigned width);
    return (bx.l < bx.r) && (bx.t < bx.b) &&
           (32'(bx.r) < width) && (bx.b < COORD_MAX);
  endfunction
endpackage

// File: rtl/box_overlay_if.sv
// Video stream plus box coordinates in, overlaid video stream out.
interface box_overlay_if #(parameter int DW = 24) ();
  import box_overlay_pkg::*;
  logic [DW-1:0] i_rgb;
  logic          i_hs;
  logic          i_vs;
  logic          i_de;
  coord_t        hcount_l;
  coord_t        hcount_r;
  coord_t        vcount_l;
  coord_t        vcount_r;
  logic [DW-1:0] o_rgb;
  logic          o_hs;
  logic          o_vs;
  logic          o_de;
  logic          box_valid;

  modport master (
    output i_rgb, i_hs, i_vs, i_de, hcount_l, hcount_r, vcount_l, vcount_r,
    input  o_rgb, o_hs, o_vs, o_de, box_valid
  );

  modport slave (
    input  i_rgb, i_hs, i_vs, i_de, hcount_l, hcount_r, vcount_l, vcount_r,
    output o_rgb, o_hs, o_vs, o_de, box_valid
  );
endinterface

// File: rtl/box_overlay_video_pos_counter.sv
// Pixel position tracker: x within the active line, y within the frame, and
// the frame-start strobe (vs falling edge).
module video_pos_counter
  import box_overlay_pkg::*;
(
  input  logic   pixelclk,
  input  logic   reset,
  input  logic   de,
  input  logic   vs,
  output coord_t x,
  output coord_t y,
  output logic   frame_start
);
  logic de_q, vs_q;

  assign frame_start = vs_q & ~vs;

  // x holds the index of the pixel currently on de; it is pre-cleared during blanking.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      de_q <= de;
      vs_q <= vs;
      if (!de)
        x <= '0;
      else if (x != COORD_MAX)
        x <= x + 1'b1;
      if (frame_start)
        y <= '0;
      else if (de_q && !de && (y != COORD_MAX))
        y <= y + 1'b1;
    end
  end
endmodule

// File: rtl/box_overlay.sv
// Draws a stabilised rectangle border over a video stream with a fixed
// two-clock latency; the box is only drawn once it has held still for a while.
module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int                        IMG_WIDTH_LINE = 1920,
  parameter int                        IMG_WIDTH_DATA = 24,
  parameter int                        LINE_W         = 2,
  parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR      = IMG_WIDTH_DATA'(DEF_BOX_COLOR),
  parameter int                        STABLE_FRAMES  = 2
) (
  input  logic          pixelclk,
  input  logic          reset,
  box_overlay_if.slave  vif
);
  coord_t x, y;
  logic   frame_start;

  video_pos_counter u_pos (
    .pixelclk    (pixelclk),
    .reset       (reset),
    .de          (vif.i_de),
    .vs          (vif.i_vs),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  box_t       box_in, cand, cand_nxt, draw, draw_nxt;
  state_t     state, state_nxt;
  logic [3:0] stab_cnt, stab_nxt;
  logic       in_ok, same, box_valid;

  assign box_in = '{l: vif.hcount_l, r: vif.hcount_r, t: vif.vcount_l, b: vif.vcount_r};
  assign in_ok  = box_ok(box_in, IMG_WIDTH_LINE);
  assign same   = (box_in == cand);

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      stab_cnt <= '0;
      cand     <= '0;
      draw     <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
      cand     <= cand_nxt;
      draw     <= draw_nxt;
    end
  end

  // Everything moves only at frame start, so the drawn box never tears mid-frame.
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    cand_nxt  = cand;
    draw_nxt  = draw;
    if (frame_start) begin
      cand_nxt = box_in;
      case (state)
        ST_IDLE: begin
          if (in_ok) begin
            stab_nxt  = 4'd1;
            state_nxt = (STABLE_FRAMES == 1) ? ST_LOCKED : ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!in_ok) begin
            stab_nxt  = '0;
            state_nxt = ST_IDLE;
          end else if (same) begin
            stab_nxt = stab_cnt + 4'd1;
            if (32'(stab_nxt) >= STABLE_FRAMES) state_nxt = ST_LOCKED;
          end else begin
            stab_nxt = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (!in_ok) begin
            stab_nxt  = '0;
            state_nxt = ST_IDLE;
          end else if (!same) begin
            stab_nxt  = 4'd1;
            state_nxt = ST_TRACK;
          end
        end
        default: begin
          stab_nxt  = '0;
          state_nxt = ST_IDLE;
        end
      endcase
      if (state_nxt == ST_LOCKED) draw_nxt = box_in;
    end
  end

  assign box_valid     = (state == ST_LOCKED);
  assign vif.box_valid = box_valid;

  // One extra bit of headroom keeps x+LINE_W and l+LINE_W from wrapping.
  logic [COORD_W:0] x13, y13, l13, r13, t13, b13, lw13;
  logic             in_box, edge_px, border;

  assign x13  = {1'b0, x};
  assign y13  = {1'b0, y};
  assign l13  = {1'b0, draw.l};
  assign r13  = {1'b0, draw.r};
  assign t13  = {1'b0, draw.t};
  assign b13  = {1'b0, draw.b};
  assign lw13 = (COORD_W+1)'(LINE_W);

  assign in_box  = (x13 >= l13) && (x13 <= r13) && (y13 >= t13) && (y13 <= b13);
  assign edge_px = (x13 < l13 + lw13) || (x13 + lw13 > r13) ||
                   (y13 < t13 + lw13) || (y13 + lw13 > b13);
  assign border  = box_valid && vif.i_de && in_box && edge_px;

  logic [1:0]                hs_p, vs_p, vld_pipe;
  logic                      border_q;
  logic [IMG_WIDTH_DATA-1:0] rgb_q, rgb_o;

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      hs_p     <= '0;
      vs_p     <= '0;
      vld_pipe <= '0;
      border_q <= 1'b0;
      rgb_q    <= '0;
      rgb_o    <= '0;
    end else begin
      hs_p     <= {hs_p[0], vif.i_hs};
      vs_p     <= {vs_p[0], vif.i_vs};
      vld_pipe <= {vld_pipe[0], vif.i_de};
      border_q <= border;
      rgb_q    <= vif.i_rgb;
      rgb_o    <= vld_pipe[0] ? (border_q ? BOX_COLOR : rgb_q) : '0;
    end
  end

  assign vif.o_hs  = hs_p[1];
  assign vif.o_vs  = vs_p[1];
  assign vif.o_de  = vld_pipe[1];
  assign vif.o_rgb = rgb_o;
endmodule

// File: doc/box_overlay.md
BOX_OVERLAY -- requirements
Module: box_overlay

Interface
REQ-001 SHALL have parameter IMG_WIDTH_LINE, default 1920, giving active pixels per line.
REQ-002 SHALL have parameter IMG_WIDTH_DATA, default 24, giving the pixel data width.
REQ-003 SHALL have parameter LINE_W, default 2, giving the border thickness in pixels (1..15).
REQ-004 SHALL have parameter BOX_COLOR, default 24'hFF0000, giving the border pixel value.
REQ-005 SHALL have parameter STABLE_FRAMES, default 2, giving the identical-box frames needed to lock (1..15).
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 pixelclk  in  1  pixel clock, all logic on rising edge.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 i_rgb  in  IMG_WIDTH_DATA  input video pixel.
REQ-010 i_hs / i_vs / i_de  in  1 each  input syncs and data enable.
REQ-011 hcount_l / hcount_r / vcount_l / vcount_r  in  12 each  box left/right/top/bottom from the projection stage.
REQ-012 o_rgb  out  IMG_WIDTH_DATA  overlaid pixel.
REQ-013 o_hs / o_vs / o_de  out  1 each  delayed syncs.
REQ-014 box_valid  out  1  high while a locked box is drawn.

Function
REQ-015 SHALL delay o_hs, o_vs, o_de and o_rgb by exactly 2 clocks from i_hs, i_vs, i_de and i_rgb.
REQ-016 SHALL keep an internal x counter: 0 on the first i_de-high cycle of a line, +1 per i_de-high cycle, cleared while i_de is low, saturating at 4095.
REQ-017 SHALL keep an internal y counter: +1 on each i_de falling edge, cleared on frame start, saturating at 4095.
REQ-018 SHALL define frame start as the i_vs falling edge (previous cycle high, current cycle low).
REQ-019 SHALL give frame start priority over an i_de falling edge in the same cycle, so y becomes 0.
REQ-020 SHALL sample all four box inputs into candidate registers only at frame start.
REQ-021 SHALL mark a candidate valid only if l < r, t < b, r < IMG_WIDTH_LINE and b < 4095.
REQ-022 SHALL implement FSM states IDLE, TRACK and LOCKED, evaluated only at frame start.
REQ-023 IDLE: a valid candidate SHALL set stab_cnt = 1 and go to TRACK, or to LOCKED if STABLE_FRAMES = 1.
REQ-024 TRACK: a candidate identical to the previous one SHALL increment stab_cnt and go to LOCKED when stab_cnt reaches STABLE_FRAMES.
REQ-025 TRACK: a different valid candidate SHALL set stab_cnt = 1 and stay in TRACK; an invalid candidate SHALL clear stab_cnt and go to IDLE.
REQ-026 LOCKED: an identical candidate SHALL stay; a different valid candidate SHALL go to TRACK with stab_cnt = 1; an invalid candidate SHALL go to IDLE.
REQ-027 SHALL copy the drawn-box registers only at frame start into LOCKED, so no mid-frame tearing occurs.
REQ-028 box_valid SHALL equal (state == LOCKED), so it changes only in the cycle after frame start.
REQ-029 SHALL treat a pixel as border when box_valid, i_de, l ≤ x ≤ r, t ≤ y ≤ b, and (x < l+LINE_W or x+LINE_W > r or y < t+LINE_W or y+LINE_W > b).
REQ-030 SHALL evaluate the border comparisons in 13-bit unsigned arithmetic, so no wrap occurs.
REQ-031 A box narrower or shorter than 2*LINE_W SHALL be drawn solid.
REQ-032 o_rgb SHALL be BOX_COLOR for border pixels, i_rgb (delayed) for other de-high pixels, and 0 when o_de is low.

Reset
REQ-033 Reset SHALL force o_rgb = 0, o_hs = o_vs = o_de = 0, box_valid = 0, state IDLE, stab_cnt 0, counters 0 and all box registers 0.
REQ-034 Reset asserted mid-frame SHALL take effect immediately; no box SHALL be drawn before the frame start that follows release.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (one-hot, 3 bits), the 12-bit coordinate width and the default BOX_COLOR.
REQ-036 The x/y counting and frame-start detection SHALL be a sub-module named video_pos_counter; the FSM and overlay SHALL be in box_overlay.

Verification
REQ-037 64x32 frames, constant box (10,50,5,20), STABLE_FRAMES = 2 -> box_valid rises after the 2nd frame start; 3rd frame pixel (10,12) = FF0000, (30,12) = input, (11,6) = FF0000.
REQ-038 Box changes mid-frame from (10,50,5,20) to (12,40,5,20) while LOCKED -> current frame unchanged; next frame start goes to TRACK and box_valid falls.
REQ-039 Invalid box l = r = 30 -> IDLE, box_valid = 0, o_rgb equals i_rgb delayed 2 clocks for the whole frame.
REQ-040 Box (0,2,0,2) with LINE_W = 2 -> 3x3 solid FF0000 block, no underflow artefacts elsewhere.
REQ-041 Reset asserted at line 10 while LOCKED -> outputs 0 within 1 clock; after release the first frame is undrawn and box_valid stays 0 until STABLE_FRAMES frame starts pass.
REQ-042 i_vs fall coincident with i_de fall -> y = 0 on the next line; syncs are delayed exactly 2 clocks.
